// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the hex keypad scanner.
// The master modport is the scanner; the slave modport is whatever sits on the
// other side (keypad matrix model plus downstream consumers).
interface hex_keypad_scanner_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_state_out;
  logic [15:0] key_change_out;
  logic        scan_done_out;

  modport master (
    input  row_in,
    output col_out,
    output key_state_out,
    output key_change_out,
    output scan_done_out
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_state_out,
    input  key_change_out,
    input  scan_done_out
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one active-low column at a time, samples the
// synchronised active-low rows at the end of each column dwell, and debounces
// every key independently into a 16-bit state vector indexed by hex value.
module hex_keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  hex_keypad_scanner_if.master    kp
);

  localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    CNT_LAST   = 4'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_e;

  col_e              col_q, col_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [3:0]        row_sync1_q, row_sync2_q;
  logic [15:0]       key_state_q, key_state_d;
  logic [15:0]       key_change_q, key_change_d;
  logic              scan_done_q, scan_done_d;
  logic [15:0][3:0]  cnt_q, cnt_d;
  logic [3:0]        key_idx;
  logic              raw_pressed;

  // Physical (row, column) position to the hex value printed on the key.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hC;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hD;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hE;
      4'b11_00: k = 4'hA;  4'b11_01: k = 4'h0;  4'b11_10: k = 4'hB;  default: k = 4'hF;
    endcase
    return k;
  endfunction

  assign kp.col_out        = ~(4'b0001 << col_q);
  assign kp.key_state_out  = key_state_q;
  assign kp.key_change_out = key_change_q;
  assign kp.scan_done_out  = scan_done_q;

  // Two-flop synchroniser for the asynchronous row inputs (idle = pulled up).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      row_sync1_q <= 4'b1111;
      row_sync2_q <= 4'b1111;
    end else begin
      row_sync1_q <= kp.row_in;
      row_sync2_q <= row_sync1_q;
    end
  end

  // Scan and debounce state registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      col_q        <= COL0;
      dwell_q      <= '0;
      key_state_q  <= '0;
      key_change_q <= '0;
      scan_done_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      col_q        <= col_d;
      dwell_q      <= dwell_d;
      key_state_q  <= key_state_d;
      key_change_q <= key_change_d;
      scan_done_q  <= scan_done_d;
      cnt_q        <= cnt_d;
    end
  end

  // Column stepping, end-of-dwell sampling and per-key debounce of the
  // four keys in the column that was driven during the dwell just ending.
  always_comb begin
    col_d        = col_q;
    dwell_d      = dwell_q + DW'(1);
    key_state_d  = key_state_q;
    key_change_d = '0;
    scan_done_d  = 1'b0;
    cnt_d        = cnt_q;
    key_idx      = '0;
    raw_pressed  = 1'b0;

    if (dwell_q == DWELL_LAST) begin
      dwell_d     = '0;
      scan_done_d = (col_q == COL3);
      unique case (col_q)
        COL0: col_d = COL1;
        COL1: col_d = COL2;
        COL2: col_d = COL3;
        COL3: col_d = COL0;
      endcase

      for (int r = 0; r < 4; r++) begin
        key_idx     = key_map(2'(r), col_q);
        raw_pressed = ~row_sync2_q[r];
        if (raw_pressed == key_state_q[key_idx]) begin
          cnt_d[key_idx] = '0;
        end else if (cnt_q[key_idx] == CNT_LAST) begin
          key_state_d[key_idx]  = raw_pressed;
          cnt_d[key_idx]        = '0;
          key_change_d[key_idx] = 1'b1;
        end else begin
          cnt_d[key_idx] = cnt_q[key_idx] + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner (SETTLE_CYCLES=8, DEBOUNCE_SCANS=3).
// A keypad matrix model closes row/column contacts for held keys; expected
// key_change/key_state events go into a scoreboard queue and are popped as
// the scanner emits change pulses.
module tb_hex_keypad_scanner;
  localparam int SETTLE = 8;
  localparam int DEB    = 3;

  typedef struct packed {
    logic [15:0] chg;
    logic [15:0] state;
  } ev_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic [15:0] held = '0;
  logic        override_en = 1'b0;
  logic [3:0]  override_val = 4'b1111;
  logic [3:0]  model_rows;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          chg_last = 0;
  int          chg_prev = 0;
  ev_t         sb[$];

  hex_keypad_scanner_if kp_if ();

  hex_keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .kp     (kp_if.master)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  // Keypad matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    model_rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[hexkey(r, c)] && !kp_if.col_out[c]) model_rows[r] = 1'b0;
  end
  assign kp_if.row_in = override_en ? override_val : model_rows;

  function automatic int hexkey(input int r, input int c);
    int tbl [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};
    return tbl[r * 4 + c];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every change pulse must match the next expected event.
  always @(negedge clk_in) begin
    if (rst_in && kp_if.key_change_out !== 16'h0) begin
      chg_prev = chg_last;
      chg_last = cyc;
      if (sb.size() == 0) begin
        check("unexpected_change", {16'h0, kp_if.key_change_out}, 32'h0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("change_pulse", {16'h0, kp_if.key_change_out}, {16'h0, e.chg});
        check("state_at_change", {16'h0, kp_if.key_state_out}, {16'h0, e.state});
      end
      $display("change cyc=%0d chg=%h state=%h", cyc, kp_if.key_change_out, kp_if.key_state_out);
    end
  end

  // Wait for n scan_done pulses, each bounded by a cycle budget.
  task automatic wait_sd(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      do begin
        @(negedge clk_in);
        t++;
      end while (!kp_if.scan_done_out && t < 100);
      if (t >= 100) check("scan_done_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic push(input logic [15:0] chg, input logic [15:0] state);
    ev_t e;
    e.chg = chg;
    e.state = state;
    sb.push_back(e);
  endtask

  initial begin
    int t;
    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_col", {28'h0, kp_if.col_out}, 32'he);
    check("rst_state", {16'h0, kp_if.key_state_out}, 32'h0);
    check("rst_change", {16'h0, kp_if.key_change_out}, 32'h0);
    check("rst_done", {31'h0, kp_if.scan_done_out}, 32'h0);
    rst_in = 1'b1;

    // Column sequence and scan_done period after release
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_in);
      check($sformatf("col_seq_%0d", n), {28'h0, kp_if.col_out},
            {28'h0, ~(4'b0001 << ((n / SETTLE) % 4))});
      if (n % 8 == 0)
        check($sformatf("done_seq_%0d", n), {31'h0, kp_if.scan_done_out},
              {31'h0, (n % 32) == 0});
    end
    check("idle_state", {16'h0, kp_if.key_state_out}, 32'h0);
    wait_sd(1);
    $display("aligned cyc=%0d", cyc);

    // Key 5: no change after 2 scans, reported on the 3rd
    held = 16'h0020;
    push(16'h0020, 16'h0020);
    wait_sd(2);
    check("k5_after2", {16'h0, kp_if.key_state_out}, 32'h0);
    wait_sd(1);
    check("k5_after3", {16'h0, kp_if.key_state_out}, 32'h20);
    check("k5_latency", cyc - chg_last, 32'd16);
    held = '0;
    push(16'h0020, 16'h0000);
    wait_sd(3);
    check("k5_released", {16'h0, kp_if.key_state_out}, 32'h0);
    check("sb_empty_k5", sb.size(), 32'd0);

    // Key 8 bounce: 2 pressed, 1 released, 3 pressed
    held = 16'h0100;
    wait_sd(2);
    held = '0;
    wait_sd(1);
    held = 16'h0100;
    push(16'h0100, 16'h0100);
    wait_sd(2);
    check("k8_bounce_2", {16'h0, kp_if.key_state_out}, 32'h0);
    wait_sd(1);
    check("k8_bounce_3", {16'h0, kp_if.key_state_out}, 32'h100);
    held = '0;
    push(16'h0100, 16'h0000);
    wait_sd(3);
    check("sb_empty_k8", sb.size(), 32'd0);

    // Keys 4 and 6 together, then released
    held = 16'h0050;
    push(16'h0010, 16'h0010);
    push(16'h0040, 16'h0050);
    wait_sd(3);
    check("k46_state", {16'h0, kp_if.key_state_out}, 32'h50);
    check("k46_gap", chg_last - chg_prev, 32'd16);
    held = '0;
    push(16'h0010, 16'h0040);
    push(16'h0040, 16'h0000);
    wait_sd(3);
    check("k46_rel_state", {16'h0, kp_if.key_state_out}, 32'h0);
    check("k46_rel_gap", chg_last - chg_prev, 32'd16);
    check("sb_empty_k46", sb.size(), 32'd0);

    // Key 0 held, then asynchronous reset mid-dwell
    held = 16'h0001;
    push(16'h0001, 16'h0001);
    wait_sd(3);
    check("k0_state", {16'h0, kp_if.key_state_out}, 32'h1);
    repeat (5) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("async_rst_state", {16'h0, kp_if.key_state_out}, 32'h0);
    check("async_rst_col", {28'h0, kp_if.col_out}, 32'he);
    check("async_rst_change", {16'h0, kp_if.key_change_out}, 32'h0);
    check("async_rst_done", {31'h0, kp_if.scan_done_out}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    push(16'h0001, 16'h0001);
    t = 0;
    do begin
      @(negedge clk_in);
      t++;
    end while (!kp_if.scan_done_out && t < 100);
    check("sd_after_reset", t, 32'd32);
    wait_sd(1);
    check("k0_rereport_2", {16'h0, kp_if.key_state_out}, 32'h0);
    wait_sd(1);
    check("k0_rereport_3", {16'h0, kp_if.key_state_out}, 32'h1);
    held = '0;
    push(16'h0001, 16'h0000);
    wait_sd(3);
    check("sb_empty_k0", sb.size(), 32'd0);

    // Synchroniser latency: row1 low from 1 cycle before the column-1 sample
    // edge is missed; from 3 cycles before it is caught.
    override_en = 1'b1;
    override_val = 4'b1111;
    for (int s = 0; s < 3; s++) begin
      repeat (14) @(negedge clk_in);
      override_val = 4'b1101;
      @(negedge clk_in);
      @(negedge clk_in);
      override_val = 4'b1111;
      wait_sd(1);
    end
    check("late_change_missed", {16'h0, kp_if.key_state_out}, 32'h0);
    push(16'h0020, 16'h0020);
    for (int s = 0; s < 3; s++) begin
      repeat (12) @(negedge clk_in);
      override_val = 4'b1101;
      repeat (4) @(negedge clk_in);
      override_val = 4'b1111;
      wait_sd(1);
    end
    check("early_change_caught", {16'h0, kp_if.key_state_out}, 32'h20);
    push(16'h0020, 16'h0000);
    wait_sd(3);
    check("sb_empty_final", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
